// File: rtl/conv3x3_frame_ctrl.sv
// Frame-level sequencer wrapped around one conv3x3 streaming instance.
// Forwards accepted raster pixels to the conv, masks windows that straddle
// the frame edge or line wrap, and registers valid-mode results into a
// backpressurable output stream with a frame-done pulse.
// Optional macro CONV3X3_FRAME_CTRL_COORD_EN adds res_x/res_y window-centre
// coordinates carried alongside res_data.

module conv3x3_frame_ctrl #(
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned OUTPUT_WIDTH = 8,
  parameter int unsigned IMAGE_WIDTH  = 8,
  parameter int unsigned HEIGHT_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [HEIGHT_WIDTH-1:0]        cfg_height,
  input  logic [PIXEL_WIDTH-1:0]         in_pixel,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [PIXEL_WIDTH-1:0]         conv_pixel_in,
  output logic                           conv_valid_in,
  input  logic signed [OUTPUT_WIDTH-1:0] conv_pixel_out,
  output logic signed [OUTPUT_WIDTH-1:0] res_data,
  output logic                           res_valid,
  input  logic                           res_ready,
`ifdef CONV3X3_FRAME_CTRL_COORD_EN
  output logic [$clog2(IMAGE_WIDTH)-1:0] res_x,
  output logic [HEIGHT_WIDTH-1:0]        res_y,
`endif
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int unsigned ColW = $clog2(IMAGE_WIDTH);
  localparam logic [ColW-1:0] ColLast = ColW'(IMAGE_WIDTH - 1);
  localparam logic [ColW-1:0] ColFirstValid = ColW'(2);
  localparam logic [HEIGHT_WIDTH-1:0] RowFirstValid = HEIGHT_WIDTH'(2);
  localparam logic [HEIGHT_WIDTH-1:0] MinHeight = HEIGHT_WIDTH'(3);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic [HEIGHT_WIDTH-1:0]        height_q, height_d;
  logic [HEIGHT_WIDTH-1:0]        row_q, row_d;
  logic [ColW-1:0]                col_q, col_d;
  logic                           p_q, p_d;
  logic                           res_valid_q, res_valid_d;
  logic signed [OUTPUT_WIDTH-1:0] res_data_q, res_data_d;
  logic                           done_q, done_d;
  logic                           cfg_err_q, cfg_err_d;

  logic start_ok, start_bad, push, last_push, win_valid, move, final_accept;

  // Decode handshake and frame events for the current cycle
  always_comb begin
    start_ok     = (state_q == StIdle) && start && !abort && (cfg_height >= MinHeight);
    start_bad    = (state_q == StIdle) && start && !abort && (cfg_height < MinHeight);
    push         = in_valid && in_ready;
    last_push    = push && (col_q == ColLast) && (row_q == height_q - HEIGHT_WIDTH'(1));
    // Only windows whose 3x3 footprint lies entirely inside this frame line
    win_valid    = (col_q >= ColFirstValid) && (row_q >= RowFirstValid);
    // Pending result advances whenever the output register is free or draining
    move         = p_q && (!res_valid_q || res_ready);
    final_accept = (state_q == StDrain) && !p_q && res_valid_q && res_ready;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_ok) state_d = StRun;
        StRun:   if (last_push) state_d = StDrain;
        StDrain: if (final_accept) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs and push path
  always_comb begin
    // A held pending result that cannot retire blocks the next push, since
    // a push would shift the conv window out from under it.
    in_ready      = (state_q == StRun) && !(p_q && res_valid_q && !res_ready);
    busy          = (state_q != StIdle);
    conv_pixel_in = in_pixel;
    conv_valid_in = push;
    res_data      = res_data_q;
    res_valid     = res_valid_q;
    done          = done_q;
    cfg_err       = cfg_err_q;
  end

  // Frame geometry: height latch and raster column/row counters
  always_comb begin
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    if (start_ok) begin
      height_d = cfg_height;
      col_d    = '0;
      row_d    = '0;
    end else if (push) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = row_q + HEIGHT_WIDTH'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // Result pipeline: pending flag and output register
  always_comb begin
    p_d         = p_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (move) begin
      // conv_pixel_out still reflects the pending window: no push since it was set
      res_data_d  = conv_pixel_out;
      res_valid_d = 1'b1;
      p_d         = 1'b0;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    if (push) begin
      p_d = win_valid;
    end
    if (abort) begin
      p_d         = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  // One-cycle status pulses
  always_comb begin
    done_d    = final_accept && !abort;
    cfg_err_d = start_bad;
  end

  // Datapath and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      p_q         <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      p_q         <= p_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

`ifdef CONV3X3_FRAME_CTRL_COORD_EN
  logic [ColW-1:0]         p_x_q, p_x_d, res_x_q, res_x_d;
  logic [HEIGHT_WIDTH-1:0] p_y_q, p_y_d, res_y_q, res_y_d;

  // Window-centre coordinates follow the same path as the result data
  always_comb begin
    p_x_d   = p_x_q;
    p_y_d   = p_y_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    if (move) begin
      res_x_d = p_x_q;
      res_y_d = p_y_q;
    end
    if (push && win_valid) begin
      p_x_d = col_q - ColW'(1);
      p_y_d = row_q - HEIGHT_WIDTH'(1);
    end
  end

  // Coordinate registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_x_q   <= '0;
      p_y_q   <= '0;
      res_x_q <= '0;
      res_y_q <= '0;
    end else begin
      p_x_q   <= p_x_d;
      p_y_q   <= p_y_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
    end
  end

  assign res_x = res_x_q;
  assign res_y = res_y_q;
`else
  // Coordinate tracking not built; results carry data only.
`endif

endmodule

// File: tb/tb_conv3x3_frame_ctrl.sv
// Self-checking bench for conv3x3_frame_ctrl. A small stand-in conv (all-ones
// 3x3 kernel, shift 0) is driven by the DUT; expected results come from
// summing 3x3 neighbourhoods of the generated frame directly.

module tb_conv3x3_frame_ctrl;

  localparam int PW = 8;
  localparam int OW = 8;
  localparam int W  = 8;
  localparam int HW = 10;
  localparam int MaxH = 8;

  logic          clk, rst_n, start, abort;
  logic [HW-1:0] cfg_height;
  logic [PW-1:0] in_pixel;
  logic          in_valid, in_ready;
  logic [PW-1:0] conv_pixel_in;
  logic          conv_valid_in;
  logic [OW-1:0] conv_pixel_out;
  logic [OW-1:0] res_data;
  logic          res_valid, res_ready;
  logic          busy, done, cfg_err;
`ifdef CONV3X3_FRAME_CTRL_COORD_EN
  logic [$clog2(W)-1:0] res_x;
  logic [HW-1:0]        res_y;
`endif

  conv3x3_frame_ctrl #(
    .PIXEL_WIDTH (PW),
    .OUTPUT_WIDTH(OW),
    .IMAGE_WIDTH (W),
    .HEIGHT_WIDTH(HW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_height    (cfg_height),
    .in_pixel      (in_pixel),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .conv_pixel_in (conv_pixel_in),
    .conv_valid_in (conv_valid_in),
    .conv_pixel_out(conv_pixel_out),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
`ifdef CONV3X3_FRAME_CTRL_COORD_EN
    .res_x         (res_x),
    .res_y         (res_y),
`endif
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in conv: two line buffers plus a 3-tap row, shifted once per push
  logic [PW-1:0] hist [0:2*W+2];
  int conv_sum;

  initial begin
    for (int i = 0; i <= 2 * W + 2; i++) hist[i] = '0;
  end

  always @(posedge clk) begin
    if (conv_valid_in) begin
      hist[0] <= conv_pixel_in;
      for (int i = 1; i <= 2 * W + 2; i++) hist[i] <= hist[i-1];
    end
  end

  always_comb begin
    conv_sum = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) conv_sum = conv_sum + int'(hist[r*W+c]);
    end
    conv_pixel_out = OW'(conv_sum);
  end

  // Reference model state
  typedef struct {
    logic [OW-1:0] d;
    int            x;
    int            y;
  } res_t;

  res_t          exp_q[$];
  logic [PW-1:0] fpix [0:MaxH-1][0:W-1];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_conv_valid_in"}, 32'(conv_valid_in), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 0);
  endtask

  // mode: 0 all ones, 1 col+10*row, 2 random
  // rdy_mode: 0 always, 1 toggle, 2 random; vld_mode: 0 always, 1 random
  // stop_kind: 0 run to done, 1 abort after stop_at pushes, 2 reset after stop_at pushes
  task automatic run_frame(input int h, input int mode, input int rdy_mode, input int vld_mode,
                           input int stop_at, input int stop_kind);
    int   total, budget, cyc, pushes, first_acc;
    int   s;
    bit   fin, prev_last_acc, acc, extra_start_done;
    res_t e;

    total = W * h;
    budget = 6 * total + 40;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < W; x++) begin
        case (mode)
          0:       fpix[y][x] = 8'd1;
          1:       fpix[y][x] = PW'(x + 10 * y);
          default: fpix[y][x] = PW'($urandom_range(0, 255));
        endcase
      end
    end
    exp_q.delete();
    for (int y = 0; y <= h - 3; y++) begin
      for (int x = 0; x <= W - 3; x++) begin
        s = 0;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++) s = s + int'(fpix[y+dy][x+dx]);
        e.d = s[OW-1:0];
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
      end
    end

    @(negedge clk);
    start = 1'b1;
    cfg_height = HW'(h);
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);

    cyc = 0;
    pushes = 0;
    first_acc = -1;
    fin = 0;
    prev_last_acc = 0;
    extra_start_done = 0;
    while (!fin && cyc < budget) begin
      if (done) begin
        check("done_after_last_accept", 32'(prev_last_acc), 1);
        check("done_all_results_out", exp_q.size(), 0);
        check("busy_low_at_done", 32'(busy), 0);
        fin = 1;
      end else if (stop_kind != 0 && pushes == stop_at) begin
        in_valid = 1'b0;
        if (stop_kind == 1) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_busy", 32'(busy), 0);
          check("abort_res_valid", 32'(res_valid), 0);
          check("abort_in_ready", 32'(in_ready), 0);
          check("abort_done", 32'(done), 0);
          @(negedge clk);
          check("abort_no_late_done", 32'(done), 0);
        end else begin
          #3 rst_n = 1'b0;
          #1 check_all_zero("async_reset");
          @(negedge clk);
          check_all_zero("reset_held");
          rst_n = 1'b1;
        end
        fin = 1;
      end else begin
        in_valid = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_pixel = (pushes < total) ? fpix[pushes / W][pushes % W] : '0;
        case (rdy_mode)
          0:       res_ready = 1'b1;
          1:       res_ready = cyc[0];
          default: res_ready = ($urandom_range(0, 2) != 0);
        endcase
        // A start (even a malformed one) while busy must be ignored
        start = 1'b0;
        if (pushes == 5 && !extra_start_done) begin
          start = 1'b1;
          cfg_height = HW'(2);
          extra_start_done = 1;
        end
        #2;
        check("no_cfg_err_while_busy", 32'(cfg_err), 0);
        check("conv_valid_is_push", 32'(conv_valid_in), 32'(in_valid && in_ready));
        check("conv_pixel_passthru", 32'(conv_pixel_in), 32'(in_pixel));
        if (pushes < total) begin
          check("in_ready_stall_rule", 32'(in_ready || (res_valid && !res_ready)), 1);
          if (rdy_mode == 0) check("in_ready_unstalled", 32'(in_ready), 1);
        end else begin
          check("in_ready_low_in_drain", 32'(in_ready), 0);
        end
        acc = res_valid && res_ready;
        prev_last_acc = 0;
        if (acc) begin
          check("result_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("res_data", 32'(res_data), 32'(e.d));
`ifdef CONV3X3_FRAME_CTRL_COORD_EN
            check("res_x", 32'(res_x), e.x);
            check("res_y", 32'(res_y), e.y);
`endif
            prev_last_acc = (exp_q.size() == 0);
          end
          if (first_acc < 0) first_acc = cyc;
        end
        if (in_valid && in_ready) pushes++;
        cyc++;
        @(negedge clk);
      end
    end
    check("frame_finished_in_budget", 32'(fin), 1);
    if (stop_kind == 0 && fin) begin
      if (rdy_mode == 0 && vld_mode == 0) begin
        check("first_result_latency", first_acc, 2 * W + 4);
        check("frame_cycle_count", cyc, total + 2);
      end
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
      check("busy_after_frame", 32'(busy), 0);
    end
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_height = '0;
    in_pixel = '0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    // Ones frame, unstalled; then with output toggling every cycle
    run_frame(6, 0, 0, 0, -1, 0);
    run_frame(6, 0, 1, 0, -1, 0);

    // Rejected start: too few lines
    @(negedge clk);
    start = 1'b1;
    cfg_height = HW'(2);
    in_valid = 1'b1;
    #2;
    check("short_start_no_push", 32'(conv_valid_in), 0);
    @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 1);
    check("cfg_err_stays_idle", 32'(busy), 0);
    check("cfg_err_in_ready", 32'(in_ready), 0);
    check("cfg_err_no_push", 32'(conv_valid_in), 0);
    @(negedge clk);
    check("cfg_err_one_cycle", 32'(cfg_err), 0);
    in_valid = 1'b0;

    // Abort beats a simultaneous start
    @(negedge clk);
    start = 1'b1;
    cfg_height = HW'(6);
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start_busy", 32'(busy), 0);
    check("abort_beats_start_cfg_err", 32'(cfg_err), 0);

    // Back-to-back coordinate-pattern frames must match the model each time
    run_frame(6, 1, 0, 0, -1, 0);
    run_frame(6, 1, 0, 0, -1, 0);

    // Random pixels with random valid/ready
    run_frame(5, 2, 2, 1, -1, 0);

    // Abort mid-frame, then a clean frame
    run_frame(6, 2, 2, 1, 20, 1);
    run_frame(6, 1, 0, 0, -1, 0);

    // Asynchronous reset mid-frame, then clean frames including minimum height
    run_frame(7, 2, 2, 1, 30, 2);
    run_frame(6, 2, 2, 1, -1, 0);
    run_frame(3, 2, 0, 0, -1, 0);
    run_frame(8, 2, 1, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_frame_ctrl.md
Name: conv3x3_frame_ctrl

Overview:
Frame-level sequencer that sits in front of and behind one conv3x3 streaming instance.
- Accepts a raster pixel stream with a valid/ready handshake and forwards accepted pixels to the conv as pixel_in/valid_in.
- Tracks column/row so only windows fully inside the frame produce results; line-wrap and previous-frame garbage are masked.
- Registers the conv result into a backpressurable output stream and reports frame completion.
- Output frame is (IMAGE_WIDTH-2) x (height-2), "valid" convolution mode.

Parameters:
PIXEL_WIDTH, 8, input pixel width; must match the conv instance
OUTPUT_WIDTH, 8, conv result width; must match the conv instance
IMAGE_WIDTH, 8, pixels per line; must match the conv instance; must be >= 3
HEIGHT_WIDTH, 10, width of the frame-height config and row counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when IDLE
abort  in  1  synchronous abort; returns to IDLE
cfg_height  in  HEIGHT_WIDTH  lines per frame; latched on accepted start
in_pixel  in  PIXEL_WIDTH  input pixel, raster order
in_valid  in  1  input pixel valid
in_ready  out  1  input can be accepted
conv_pixel_in  out  PIXEL_WIDTH  to conv pixel_in
conv_valid_in  out  1  to conv valid_in
conv_pixel_out  in  OUTPUT_WIDTH (signed)  from conv pixel_out
res_data  out  OUTPUT_WIDTH (signed)  result pixel
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last result of a frame is accepted
cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
Reset values:
- All outputs 0; res_data 0; state IDLE; counters 0; pending flag p = 0.

Push path:
- conv_pixel_in = in_pixel (combinational).
- conv_valid_in = in_valid && in_ready. A push is exactly one conv shift.

States:
- IDLE:
  - start with cfg_height >= 3: latch height, clear col/row, go RUN.
  - start with cfg_height < 3: pulse cfg_err next cycle, stay IDLE.
  - start while not IDLE is ignored.
- RUN:
  - in_ready = !(p && res_valid && !res_ready).
  - On each push: col increments and wraps at IMAGE_WIDTH-1 to 0, incrementing row.
  - On push of col=IMAGE_WIDTH-1, row=height-1: go DRAIN.
- DRAIN:
  - in_ready = 0.
  - When p==0 and the final result is accepted (res_valid && res_ready): pulse done for 1 cycle, go IDLE.
- abort, any state: next cycle state IDLE, p=0, res_valid=0, in_ready=0; no done pulse. abort wins over start in the same cycle.

Result pipeline (conv output is combinational from its window, which updates on the push edge):
- Push of (col,row) with col>=2 && row>=2 sets p=1 on that edge. Otherwise p is cleared if it moves.
- p moves to the result register when !res_valid || res_ready: res_data <= conv_pixel_out, res_valid <= 1, p <= p_new.
- res_valid clears on accept when nothing moves in.
- While p is held with no push, the conv window is frozen, so conv_pixel_out stays stable.
- Latency: push edge -> res_valid at +2 edges when the output is unstalled.
- Throughput: 1 pixel/cycle with res_ready held high.

Boundary conditions:
- Results per frame = (IMAGE_WIDTH-2)*(height-2), in raster order of window centres (col-1, row-1).
- Rows 0-1 and cols 0-1 of each row never produce results, which also masks stale line-buffer data from the previous frame. The conv's own valid_out is ignored.
- in_valid in IDLE/DRAIN: not accepted, no conv shift.
- Next start is accepted only after return to IDLE; the conv needs no reset between frames.

Optional Feature:
Macro CONV3X3_FRAME_CTRL_COORD_EN.
- Defined: adds outputs res_x (clog2(IMAGE_WIDTH) bits) and res_y (HEIGHT_WIDTH bits), the zero-based window-centre coordinates. They are carried through p and the result register alongside res_data, equal col-1 and row-1 of the originating push, and reset to 0.
- Undefined: the ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
1. IMAGE_WIDTH=8, cfg_height=6, all pixels 1, conv all-ones kernel, shift 0, res_ready=1 -> exactly 24 results, each 9; done pulses once, 1 cycle after the 24th accept; busy low afterward.
2. Same frame with res_ready toggling 1/0 every cycle -> still 24 results in order, none lost or duplicated; in_ready drops only when p && res_valid && !res_ready.
3. Pixel value = col+10*row, two back-to-back frames -> second frame results identical to first (no stale-row leakage); with COORD_EN, first result (0,0), last (5,3).
4. start with cfg_height=2 -> cfg_err pulse, state stays IDLE, in_ready 0, no conv_valid_in.
5. abort after 20 pixels of a height-6 frame -> next cycle busy=0, res_valid=0, no done; a following start plus full frame yields 24 correct results.
6. rst_n asserted mid-frame -> all outputs 0 immediately (asynchronous); frame restarts cleanly after release.
